// File: rtl/vga_box_renderer_if.sv
// Pixel-stream bundle between a VGA timing generator and the box renderer.
// master drives timing/pixel inputs; slave is the renderer.
interface vga_box_renderer_if;
    logic       clk_25MHz;
    logic [9:0] x;
    logic [9:0] y;
    logic       xyvalid;
    logic       hsync_in;
    logic       vsync_in;
    logic       pause;
    logic       hsync_out;
    logic       vsync_out;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       frame_tick;
    logic [9:0] box_x;
    logic [9:0] box_y;

    modport master (
        output clk_25MHz, x, y, xyvalid, hsync_in, vsync_in, pause,
        input  hsync_out, vsync_out, red, green, blue, frame_tick, box_x, box_y
    );

    modport slave (
        input  clk_25MHz, x, y, xyvalid, hsync_in, vsync_in, pause,
        output hsync_out, vsync_out, red, green, blue, frame_tick, box_x, box_y
    );
endinterface

// File: rtl/vga_box_renderer.sv
// Two-stage pixel pipeline drawing a bouncing box over a background.
// Define VGA_RENDER_GRID_EN to overlay a 32-pixel grid on the background.
module vga_box_renderer #(
    parameter int unsigned BOX_W      = 32,
    parameter int unsigned BOX_H      = 32,
    parameter int unsigned STEP       = 2,
    parameter logic [11:0] BOX_COLOR  = 12'hF00,
    parameter logic [11:0] BG_COLOR   = 12'h00F,
    parameter logic [11:0] GRID_COLOR = 12'hFFF
) (
    input logic                clk,
    input logic                clr_n,
    vga_box_renderer_if.slave  vga
);

    localparam logic [10:0] BoxW  = 11'(BOX_W);
    localparam logic [10:0] BoxH  = 11'(BOX_H);
    localparam logic [10:0] StepW = 11'(STEP);
    localparam logic [10:0] XLim  = 11'(640 - BOX_W);
    localparam logic [10:0] YLim  = 11'(480 - BOX_H);

    typedef enum logic {StRight, StLeft} h_state_e;
    typedef enum logic {StDown, StUp} v_state_e;

    logic [9:0]  x_q, y_q;
    logic        valid_q, hs1_q, vs1_q;
    logic [11:0] color_q, color_d;
    logic        hs2_q, vs2_q;
    logic        vs_hist_q, frame_tick_q;
    logic        box_hit, grid_hit;
    logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
    h_state_e    h_state_q, h_state_d;
    v_state_e    v_state_q, v_state_d;

    // Pixel pipeline and vsync edge detector, all gated by the pixel enable.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            x_q          <= '0;
            y_q          <= '0;
            valid_q      <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            color_q      <= '0;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
            vs_hist_q    <= 1'b1;
            frame_tick_q <= 1'b0;
        end else if (vga.clk_25MHz) begin
            x_q          <= vga.x;
            y_q          <= vga.y;
            valid_q      <= vga.xyvalid;
            hs1_q        <= vga.hsync_in;
            vs1_q        <= vga.vsync_in;
            color_q      <= color_d;
            hs2_q        <= hs1_q;
            vs2_q        <= vs1_q;
            vs_hist_q    <= vga.vsync_in;
            frame_tick_q <= vs_hist_q & ~vga.vsync_in;
        end else begin
            frame_tick_q <= 1'b0;
        end
    end

    // 11-bit compares keep box_x+BOX_W from wrapping near the right edge.
    always_comb begin
        box_hit = ({1'b0, box_x_q} <= {1'b0, x_q}) && ({1'b0, x_q} < {1'b0, box_x_q} + BoxW) &&
                  ({1'b0, box_y_q} <= {1'b0, y_q}) && ({1'b0, y_q} < {1'b0, box_y_q} + BoxH);
    end

`ifdef VGA_RENDER_GRID_EN
    assign grid_hit = valid_q && ((x_q[4:0] == 5'd0) || (y_q[4:0] == 5'd0));
`else
    assign grid_hit = 1'b0;
`endif

    always_comb begin
        color_d = BG_COLOR;
        if (!valid_q)      color_d = 12'h000;
        else if (box_hit)  color_d = BOX_COLOR;
        else if (grid_hit) color_d = GRID_COLOR;
    end

    // Motion FSMs: advance once per unpaused frame tick, clamping at the edges.
    always_comb begin
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        box_x_d   = box_x_q;
        box_y_d   = box_y_q;
        if (frame_tick_q && !vga.pause) begin
            unique case (h_state_q)
                StRight: begin
                    if ({1'b0, box_x_q} + StepW >= XLim) begin
                        box_x_d   = XLim[9:0];
                        h_state_d = StLeft;
                    end else begin
                        box_x_d = box_x_q + StepW[9:0];
                    end
                end
                StLeft: begin
                    if ({1'b0, box_x_q} <= StepW) begin
                        box_x_d   = '0;
                        h_state_d = StRight;
                    end else begin
                        box_x_d = box_x_q - StepW[9:0];
                    end
                end
            endcase
            unique case (v_state_q)
                StDown: begin
                    if ({1'b0, box_y_q} + StepW >= YLim) begin
                        box_y_d   = YLim[9:0];
                        v_state_d = StUp;
                    end else begin
                        box_y_d = box_y_q + StepW[9:0];
                    end
                end
                StUp: begin
                    if ({1'b0, box_y_q} <= StepW) begin
                        box_y_d   = '0;
                        v_state_d = StDown;
                    end else begin
                        box_y_d = box_y_q - StepW[9:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            box_x_q   <= '0;
            box_y_q   <= '0;
            h_state_q <= StRight;
            v_state_q <= StDown;
        end else begin
            box_x_q   <= box_x_d;
            box_y_q   <= box_y_d;
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
        end
    end

    assign vga.hsync_out  = hs2_q;
    assign vga.vsync_out  = vs2_q;
    assign vga.red        = color_q[11:8];
    assign vga.green      = color_q[7:4];
    assign vga.blue       = color_q[3:0];
    assign vga.frame_tick = frame_tick_q;
    assign vga.box_x      = box_x_q;
    assign vga.box_y      = box_y_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Scoreboard bench for vga_box_renderer: a cycle model predicts frame ticks and box
// motion, and expected pixels are queued at drive time and popped as they emerge.
module tb_vga_box_renderer;
    localparam int BoxW = 32;
    localparam int BoxH = 32;
    localparam int Step = 2;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    vga_box_renderer_if vga ();

    vga_box_renderer dut (
        .clk   (clk),
        .clr_n (clr_n),
        .vga   (vga)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int  m_bx, m_by;
    bit  m_left, m_up;
    bit  m_hist, m_tick;
    bit  in_pause;
    int  pause_ticks;
    int  cyc;
    logic [13:0] sb_q[$];
    logic [13:0] last_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input int x, input int y, input bit v);
        if (!v) return 12'h000;
        if (x >= m_bx && x < m_bx + BoxW && y >= m_by && y < m_by + BoxH) return 12'hF00;
`ifdef VGA_RENDER_GRID_EN
        if ((x % 32) == 0 || (y % 32) == 0) return 12'hFFF;
`endif
        return 12'h00F;
    endfunction

    task automatic model_move();
        if (!m_left) begin
            if (m_bx + Step >= 640 - BoxW) begin m_bx = 640 - BoxW; m_left = 1'b1; end
            else m_bx += Step;
        end else begin
            if (m_bx <= Step) begin m_bx = 0; m_left = 1'b0; end
            else m_bx -= Step;
        end
        if (!m_up) begin
            if (m_by + Step >= 480 - BoxH) begin m_by = 480 - BoxH; m_up = 1'b1; end
            else m_by += Step;
        end else begin
            if (m_by <= Step) begin m_by = 0; m_up = 1'b0; end
            else m_by -= Step;
        end
    endtask

    task automatic model_reset();
        m_bx = 0; m_by = 0; m_left = 1'b0; m_up = 1'b0;
        m_hist = 1'b1; m_tick = 1'b0;
        sb_q.delete();
        last_exp = {1'b1, 1'b1, 12'h000};
        sb_q.push_back(last_exp);  // stage-1 reset contents emerge first
    endtask

    // One clk cycle: drive at negedge, advance the model at posedge, compare #1 later.
    task automatic cycle(input int x, input int y, input bit v, input bit hs, input bit vs,
                         input bit en, input bit ps);
        @(negedge clk);
        vga.x         = 10'(x);
        vga.y         = 10'(y);
        vga.xyvalid   = v;
        vga.hsync_in  = hs;
        vga.vsync_in  = vs;
        vga.clk_25MHz = en;
        vga.pause     = ps;
        if (en) sb_q.push_back({hs, vs, exp_rgb(x, y, v)});
        @(posedge clk);
        if (m_tick && !ps) model_move();
        if (en) begin
            m_tick = m_hist & ~vs;
            m_hist = vs;
        end else begin
            m_tick = 1'b0;
        end
        #1;
        if (vga.frame_tick === 1'b1 && in_pause) pause_ticks++;
        check("frame_tick", vga.frame_tick, m_tick);
        check("box_x", vga.box_x, m_bx);
        check("box_y", vga.box_y, m_by);
        if (en && sb_q.size() == 2) last_exp = sb_q.pop_front();
        check("hsync_out", vga.hsync_out, last_exp[13]);
        check("vsync_out", vga.vsync_out, last_exp[12]);
        check("rgb", {vga.red, vga.green, vga.blue}, last_exp[11:0]);
    endtask

    // Pixel enable drops one cycle in seven; never twice in a row.
    task automatic pcycle(input int x, input int y, input bit v, input bit hs, input bit vs,
                          input bit ps);
        bit en;
        en = (cyc % 7) != 6;
        cyc++;
        if (en) cycle(x, y, v, hs, vs, 1'b1, ps);
        else cycle(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1,
                   1'b0, 1'b0, 1'b0, ps);
    endtask

    function automatic int cx(input int x);
        return (x < 0 || x > 639) ? 0 : x;
    endfunction

    function automatic int cy(input int y);
        return (y < 0 || y > 479) ? 0 : y;
    endfunction

    task automatic active_pixels(input bit ps);
        int px[7];
        int py[7];
        px[0] = m_bx + 1;        py[0] = m_by + 1;
        px[1] = m_bx + BoxW - 1; py[1] = m_by + BoxH - 1;
        px[2] = m_bx + BoxW;     py[2] = m_by;
        px[3] = m_bx - 1;        py[3] = m_by + BoxH;
        px[4] = 64;              py[4] = 100;
        px[5] = 5;               py[5] = 5;
        px[6] = int'($urandom_range(0, 639)); py[6] = int'($urandom_range(0, 479));
        for (int i = 0; i < 7; i++)
            pcycle(cx(px[i]), cy(py[i]), 1'b1, 1'(i % 2), 1'b1, ps);
    endtask

    task automatic run_frame(input bit ps);
        active_pixels(ps);
        for (int i = 0; i < 3; i++) pcycle(cx(m_bx + 2), cy(m_by + 2), 1'b0, 1'b1, 1'b1, ps);
        for (int i = 0; i < 3; i++) pcycle(0, 0, 1'b0, 1'b1, 1'b0, ps);
        for (int i = 0; i < 3; i++) pcycle(0, 0, 1'b0, 1'b1, 1'b1, ps);
    endtask

    initial begin
        int guard;
        int hold_x, hold_y;
        cyc = 0; in_pause = 1'b0; pause_ticks = 0;
        vga.clk_25MHz = 1'b1; vga.x = '0; vga.y = '0; vga.xyvalid = 1'b0;
        vga.hsync_in = 1'b1; vga.vsync_in = 1'b0; vga.pause = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hsync", vga.hsync_out, 1'b1);
        check("rst_vsync", vga.vsync_out, 1'b1);
        check("rst_rgb", {vga.red, vga.green, vga.blue}, 12'h000);
        check("rst_tick", vga.frame_tick, 1'b0);
        check("rst_box", {vga.box_x, vga.box_y}, 20'h0);
        @(negedge clk);
        vga.vsync_in = 1'b1;
        clr_n = 1'b1;

        // Latency and grid/background with the box at (0,0).
        cycle(5, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(64, 100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("lat_rgb", {vga.red, vga.green, vga.blue}, 12'hF00);
        check("lat_hsync", vga.hsync_out, 1'b0);
        cycle(40, 40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("hold_rgb", {vga.red, vga.green, vga.blue}, 12'hF00);
        cycle(10, 10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef VGA_RENDER_GRID_EN
        check("grid_rgb", {vga.red, vga.green, vga.blue}, 12'hFFF);
`else
        check("grid_rgb", {vga.red, vga.green, vga.blue}, 12'h00F);
`endif
        cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("blank_rgb", {vga.red, vga.green, vga.blue}, 12'h000);

        run_frame(1'b0);
        run_frame(1'b0);
        check("move_x", vga.box_x, 4);

        hold_x = m_bx; hold_y = m_by;
        in_pause = 1'b1;
        for (int f = 0; f < 3; f++) run_frame(1'b1);
        in_pause = 1'b0;
        check("pause_ticks", pause_ticks, 3);
        check("pause_x", vga.box_x, hold_x);
        check("pause_y", vga.box_y, hold_y);

        guard = 0;
        while (!(m_by == 446 && !m_up) && guard < 400) begin run_frame(1'b0); guard++; end
        check("reach_y446", vga.box_y, 446);
        run_frame(1'b0);
        check("bounce_y448", vga.box_y, 448);
        run_frame(1'b0);
        check("bounce_y446", vga.box_y, 446);

        guard = 0;
        while (!(m_bx == 604 && !m_left) && guard < 400) begin run_frame(1'b0); guard++; end
        check("reach_x604", vga.box_x, 604);
        run_frame(1'b0);
        check("bounce_x606", vga.box_x, 606);
        run_frame(1'b0);
        check("bounce_x608", vga.box_x, 608);
        run_frame(1'b0);
        check("bounce_x606b", vga.box_x, 606);

        // Mid-frame asynchronous reset, released while vsync stays high.
        active_pixels(1'b0);
        #2 clr_n = 1'b0;
        #1;
        check("mrst_hsync", vga.hsync_out, 1'b1);
        check("mrst_vsync", vga.vsync_out, 1'b1);
        check("mrst_rgb", {vga.red, vga.green, vga.blue}, 12'h000);
        check("mrst_tick", vga.frame_tick, 1'b0);
        check("mrst_box", {vga.box_x, vga.box_y}, 20'h0);
        model_reset();
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        for (int i = 0; i < 6; i++) pcycle(100, 100, 1'b1, 1'b1, 1'b1, 1'b0);
        check("mrst_still_x", vga.box_x, 0);
        run_frame(1'b0);
        check("mrst_first_x", vga.box_x, 2);
        check("mrst_first_y", vga.box_y, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
